// File: rtl/ram_arbiter.sv
// ram_arbiter -- shares one SRAM controller between a bootloader write port,
// an instruction-fetch read port and a CPU data port.
//
// While boot_done is low only the bootloader is served. Once boot_done is high,
// the bootloader is ignored and IF/MEM are arbitrated. Each transaction goes
// IDLE -> GRANT_x -> DONE -> IDLE. ram_* outputs are registered on the grant
// edge and held until ram_work_done is sampled. The port's ack is then pulsed
// for the single DONE cycle.
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin between IF and MEM
// on a tie. The default build uses fixed priority, MEM over IF.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   boot_*              bootloader write port (req/addr/data in, ack out)
//   if_*                instruction fetch read port (req/addr in, data/ack out)
//   mem_*               CPU data port (req/we/addr/wdata in, rdata/ack out)
//   ram_*               SRAM controller handshake (need_to_work/we/addr/wdata out,
//                       rdata/work_done in)
//   busy                high whenever the FSM is not in IDLE
module ram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_done,
    input  logic        boot_req,
    input  logic [17:0] boot_addr,
    input  logic [15:0] boot_data,
    output logic        boot_ack,
    input  logic        if_req,
    input  logic [17:0] if_addr,
    output logic [15:0] if_data,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [17:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ack,
    output logic        ram_need_to_work,
    output logic        ram_we,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        ram_work_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_BOOT,
        GRANT_IF,
        GRANT_MEM,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        ram_need_to_work_q, ram_need_to_work_d;
    logic        ram_we_q, ram_we_d;
    logic [17:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic        boot_ack_q, boot_ack_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic [15:0] if_data_q, if_data_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;

    // pick_mem only matters in IDLE with at least one of IF/MEM requesting.
    logic pick_mem;

`ifdef ARB_ROUND_ROBIN_EN
    // High when the most recent IF/MEM grant went to IF.
    logic last_if_q, last_if_d;
    assign pick_mem = mem_req && (!if_req || last_if_q);
`else
    assign pick_mem = mem_req;
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so a path
        // that does not mention it holds the flop value instead of inferring a latch.
        state_d            = state_q;
        ram_need_to_work_d = ram_need_to_work_q;
        ram_we_d           = ram_we_q;
        ram_addr_d         = ram_addr_q;
        ram_wdata_d        = ram_wdata_q;
        boot_ack_d         = 1'b0;
        if_ack_d           = 1'b0;
        mem_ack_d          = 1'b0;
        if_data_d          = if_data_q;
        mem_rdata_d        = mem_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_if_d          = last_if_q;
`endif

        case (state_q)
            IDLE: begin
                if (!boot_done) begin
                    if (boot_req) begin
                        state_d            = GRANT_BOOT;
                        ram_need_to_work_d = 1'b1;
                        ram_we_d           = 1'b1;
                        ram_addr_d         = boot_addr;
                        ram_wdata_d        = boot_data;
                    end
                end else if (if_req || mem_req) begin
                    ram_need_to_work_d = 1'b1;
                    if (pick_mem) begin
                        state_d     = GRANT_MEM;
                        ram_we_d    = mem_we;
                        ram_addr_d  = mem_addr;
                        ram_wdata_d = mem_wdata;
                    end else begin
                        state_d     = GRANT_IF;
                        ram_we_d    = 1'b0;
                        ram_addr_d  = if_addr;
                        ram_wdata_d = 16'h0000;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_if_d = !pick_mem;
`endif
                end
            end

            GRANT_BOOT, GRANT_IF, GRANT_MEM: begin
                // Requester inputs are not looked at here; the ram_* flops
                // simply hold what was captured on the grant edge.
                if (ram_work_done) begin
                    state_d            = DONE;
                    ram_need_to_work_d = 1'b0;
                    ram_we_d           = 1'b0;
                    case (state_q)
                        GRANT_BOOT: boot_ack_d = 1'b1;
                        GRANT_IF: begin
                            if_ack_d  = 1'b1;
                            if_data_d = ram_rdata;
                        end
                        default: begin
                            mem_ack_d = 1'b1;
                            if (!ram_we_q) begin
                                mem_rdata_d = ram_rdata;
                            end
                        end
                    endcase
                end
            end

            // One-cycle ack slot; requests are ignored so the requester has
            // time to drop req after seeing ack.
            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            ram_need_to_work_q <= 1'b0;
            ram_we_q           <= 1'b0;
            ram_addr_q         <= 18'h0;
            ram_wdata_q        <= 16'h0;
            boot_ack_q         <= 1'b0;
            if_ack_q           <= 1'b0;
            mem_ack_q          <= 1'b0;
            if_data_q          <= 16'h0;
            mem_rdata_q        <= 16'h0;
`ifdef ARB_ROUND_ROBIN_EN
            last_if_q          <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop updates from the
            // pre-edge values, independent of statement order.
            state_q            <= state_d;
            ram_need_to_work_q <= ram_need_to_work_d;
            ram_we_q           <= ram_we_d;
            ram_addr_q         <= ram_addr_d;
            ram_wdata_q        <= ram_wdata_d;
            boot_ack_q         <= boot_ack_d;
            if_ack_q           <= if_ack_d;
            mem_ack_q          <= mem_ack_d;
            if_data_q          <= if_data_d;
            mem_rdata_q        <= mem_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_if_q          <= last_if_d;
`endif
        end
    end

    assign ram_need_to_work = ram_need_to_work_q;
    assign ram_we           = ram_we_q;
    assign ram_addr         = ram_addr_q;
    assign ram_wdata        = ram_wdata_q;
    assign boot_ack         = boot_ack_q;
    assign if_ack           = if_ack_q;
    assign mem_ack          = mem_ack_q;
    assign if_data          = if_data_q;
    assign mem_rdata        = mem_rdata_q;
    assign busy             = (state_q != IDLE);

endmodule
